// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds funct3 access sizes, the FSM state type and a legality check.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    function automatic logic size_legal(input logic [2:0] s);
        size_legal = (s == SZ_B)  || (s == SZ_H)  || (s == SZ_W) ||
                     (s == SZ_BU) || (s == SZ_HU);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for sub-word loads and stores.
// Produces store byte enables, replicated write data and load extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlane,
    output logic [31:0] rdata,
    output logic        misal
);

    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    assign shifted = rword >> {off, 3'b000};
    assign b       = shifted[7:0];
    assign h       = shifted[15:0];

    // Decode size and lane into enables, write lanes and load result.
    always_comb begin
        be    = 4'b0000;
        wlane = wdata;
        rdata = rword;
        misal = 1'b0;
        case (size)
            SZ_B: begin
                be    = 4'b0001 << off;
                wlane = {4{wdata[7:0]}};
                rdata = {{24{b[7]}}, b};
            end
            SZ_BU: begin
                be    = 4'b0001 << off;
                wlane = {4{wdata[7:0]}};
                rdata = {24'h0, b};
            end
            SZ_H: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
                rdata = {{16{h[15]}}, h};
                misal = off[0];
            end
            SZ_HU: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
                rdata = {16'h0, h};
                misal = off[0];
            end
            SZ_W: begin
                be    = 4'b1111;
                misal = |off;
            end
            default: begin
                be    = 4'b0000;
                misal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with wait states over a word-organised RAM.
// Optional fault detection is enabled by defining DMEM_FAULT_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDXW = $clog2(DEPTH_WORDS);
    localparam int AW   = IDXW + 2;
    localparam int CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            accept, access, fault;

    logic            lat_we;
    logic [2:0]      lat_size;
    logic [AW-1:0]   lat_addr;
    logic [31:0]     lat_wdata;

    logic            in_idle;
    logic            sel_we;
    logic [2:0]      sel_size;
    logic [AW-1:0]   sel_addr;
    logic [31:0]     sel_wdata;
    logic [2:0]      eff_size;
    logic [1:0]      eff_off;
    logic [IDXW-1:0] idx;

    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     rword, wlane, ext;
    logic [3:0]      be;
    logic            misal;
    logic [31:0]     rdata_q;
    logic            err_q;

    // In IDLE the live request drives the datapath; later the latch does.
    assign in_idle   = (state == IDLE);
    assign sel_we    = in_idle ? req_we : lat_we;
    assign sel_size  = in_idle ? req_size : lat_size;
    assign sel_addr  = in_idle ? req_addr[AW-1:0] : lat_addr;
    assign sel_wdata = in_idle ? req_wdata : lat_wdata;

`ifdef DMEM_FAULT_EN
    assign eff_size = sel_size;
    assign eff_off  = sel_addr[1:0];
    assign fault    = misal | ~size_legal(sel_size)
                    | (|req_addr[31:AW]);
`else
    logic unused_bits;

    // Without fault checking, coerce the request into a legal access.
    always_comb begin
        eff_size = size_legal(sel_size) ? sel_size : SZ_W;
        eff_off  = sel_addr[1:0];
        if (eff_size == SZ_W) begin
            eff_off = 2'b00;
        end else if (eff_size == SZ_H || eff_size == SZ_HU) begin
            eff_off[0] = 1'b0;
        end
    end

    assign fault       = 1'b0;
    assign unused_bits = ^{misal, req_addr[31:AW]};
`endif

    assign idx   = sel_addr[AW-1:2];
    assign rword = mem[idx];

    dmem_lane_align u_align (
        .size  (eff_size),
        .off   (eff_off),
        .wdata (sel_wdata),
        .rword (rword),
        .be    (be),
        .wlane (wlane),
        .rdata (ext),
        .misal (misal)
    );

    // State and wait counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state logic, counter update and access strobe.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = 1'b0;
        access  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (fault) begin
                        state_d = RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CW'(WAIT_CYCLES - 1);
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the request so BUSY works from stable values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_size  <= 3'b000;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_we    <= req_we;
            lat_size  <= req_size;
            lat_addr  <= req_addr[AW-1:0];
            lat_wdata <= req_wdata;
        end
    end

    // Byte-masked RAM write; reset blocks a pending commit.
    always_ff @(posedge clk) begin
        if (reset && access && sel_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    // Response data and error, valid only while in RESP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept && fault) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end else if (access) begin
            rdata_q <= sel_we ? 32'h0 : ext;
            err_q   <= 1'b0;
        end else if (state == RESP) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end
    end

    assign req_ready = in_idle;
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with hand-computed expectations.
// Covers both DMEM_FAULT_EN builds via matching preprocessor branches.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          seen;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (256),
        .WAIT_CYCLES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic we, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic hold, output logic [31:0] r,
                       output logic e, output int l);
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        req_we    = we;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        l = 1;
        if (!hold) req_valid = 1'b0;
        while (!rsp_valid && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
        r = rsp_rdata;
        e = rsp_err;
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = SZ_W;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;

        txn(1'b1, SZ_W, 32'h10, 32'hDEADBEEF, 1'b1, rd, er, lat);
        chk("sw_lat", lat, 3);
        chk("sw_rdata", rd, 32'h0);
        chk("sw_err", 32'(er), 32'd0);
        seen = 0;
        repeat (4) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        chk("no_double", seen, 0);

        txn(1'b0, SZ_W, 32'h10, 32'h0, 1'b0, rd, er, lat);
        chk("lw_lat", lat, 3);
        chk("lw_data", rd, 32'hDEADBEEF);
        chk("lw_err", 32'(er), 32'd0);

        txn(1'b0, SZ_B, 32'h13, 32'h0, 1'b0, rd, er, lat);
        chk("lb_13", rd, 32'hFFFFFFDE);
        txn(1'b0, SZ_BU, 32'h13, 32'h0, 1'b0, rd, er, lat);
        chk("lbu_13", rd, 32'h000000DE);
        txn(1'b0, SZ_H, 32'h12, 32'h0, 1'b0, rd, er, lat);
        chk("lh_12", rd, 32'hFFFFDEAD);
        txn(1'b0, SZ_HU, 32'h10, 32'h0, 1'b0, rd, er, lat);
        chk("lhu_10", rd, 32'h0000BEEF);
        txn(1'b0, SZ_B, 32'h11, 32'h0, 1'b0, rd, er, lat);
        chk("lb_11", rd, 32'hFFFFFFBE);

        txn(1'b1, SZ_B, 32'h11, 32'h123456AA, 1'b0, rd, er, lat);
        txn(1'b0, SZ_W, 32'h10, 32'h0, 1'b0, rd, er, lat);
        chk("sb_merge", rd, 32'hDEADAAEF);
        txn(1'b1, SZ_H, 32'h12, 32'h00007777, 1'b0, rd, er, lat);
        txn(1'b0, SZ_W, 32'h10, 32'h0, 1'b0, rd, er, lat);
        chk("sh_merge", rd, 32'h7777AAEF);

        txn(1'b1, SZ_W, 32'h0, 32'h01234567, 1'b0, rd, er, lat);
        txn(1'b0, SZ_W, 32'h0, 32'h0, 1'b0, rd, er, lat);
        chk("lw_0", rd, 32'h01234567);

`ifdef DMEM_FAULT_EN
        txn(1'b0, SZ_W, 32'h12, 32'h0, 1'b0, rd, er, lat);
        chk("mis_lat", lat, 1);
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_rdata", rd, 32'h0);
        txn(1'b0, 3'b011, 32'h10, 32'h0, 1'b0, rd, er, lat);
        chk("ill_err", 32'(er), 32'd1);
        chk("ill_lat", lat, 1);
        txn(1'b1, SZ_W, 32'h400, 32'hFFFFFFFF, 1'b0, rd, er, lat);
        chk("oob_err", 32'(er), 32'd1);
        chk("oob_lat", lat, 1);
        txn(1'b0, SZ_W, 32'h0, 32'h0, 1'b0, rd, er, lat);
        chk("oob_keep", rd, 32'h01234567);
        chk("oob_keep_err", 32'(er), 32'd0);
`else
        txn(1'b0, SZ_W, 32'h12, 32'h0, 1'b0, rd, er, lat);
        chk("mis_lat", lat, 3);
        chk("mis_err", 32'(er), 32'd0);
        chk("mis_align", rd, 32'h7777AAEF);
        txn(1'b0, SZ_H, 32'h13, 32'h0, 1'b0, rd, er, lat);
        chk("lh_align", rd, 32'h00007777);
        txn(1'b0, 3'b011, 32'h10, 32'h0, 1'b0, rd, er, lat);
        chk("ill_as_lw", rd, 32'h7777AAEF);
        txn(1'b1, SZ_W, 32'h400, 32'hFFFFFFFF, 1'b0, rd, er, lat);
        chk("wrap_err", 32'(er), 32'd0);
        txn(1'b0, SZ_W, 32'h0, 32'h0, 1'b0, rd, er, lat);
        chk("wrap_data", rd, 32'hFFFFFFFF);
`endif

        txn(1'b1, SZ_W, 32'h20, 32'h11112222, 1'b0, rd, er, lat);
        req_we    = 1'b1;
        req_size  = SZ_W;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset     = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        seen = 0;
        repeat (5) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        chk("abort_norsp", seen, 0);
        txn(1'b0, SZ_W, 32'h20, 32'h0, 1'b0, rd, er, lat);
        chk("abort_keep", rd, 32'h11112222);
        chk("abort_lat", lat, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the RISC-V datapath's load/store port. It accepts one request at a time through a valid/ready handshake, inserts a configurable number of wait states, and performs byte, halfword or word accesses on an internal word-organised RAM. Loads return sign- or zero-extended data, and stores merge bytes into the stored word. The datapath's stall logic waits on `rsp_valid` before it retires a load or store.

## Interface
- `DEPTH_WORDS`, 256: RAM depth in 32-bit words; must be a power of two.
- `WAIT_CYCLES`, 2: wait states between accept and access; 0 is legal.
- `clk` in 1: sole clock; every register updates on the rising edge.
- `reset` in 1: synchronous, active-low. Asserted when 0 and sampled on `clk`.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept; high only in IDLE.
- `req_we` in 1: 1 means store, 0 means load.
- `req_size` in 3: RISC-V funct3 encoding: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu. Any other value is illegal.
- `req_addr` in 32: byte address (ALUResult).
- `req_wdata` in 32: store data (WriteData); the low byte or low halfword is used for sb/sh.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: the request faulted; qualified by `rsp_valid`.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid` the responder latches we/size/addr/wdata and computes fault.
  - Fault → RESP.
  - No fault with WAIT_CYCLES = 0 → RESP, performing the access on the same edge.
  - Otherwise → BUSY, with the wait counter loaded with WAIT_CYCLES-1.
- BUSY:
  - Counter decrements each cycle.
  - At 0 the access is performed on that edge (store commits, load data registered) → RESP.
  - Requests are ignored because `req_ready` = 0.
- RESP:
  - `rsp_valid` = 1 for exactly one cycle, with registered `rsp_rdata`/`rsp_err`.
  - Next state is IDLE unconditionally. There is no back-pressure on the response.
- Fault conditions:
  - Misaligned access: lh/lhu/sh with addr[0] = 1, or lw/sw with addr[1:0] ≠ 0.
  - Illegal `req_size`.
  - Word index addr[31:2] ≥ DEPTH_WORDS.
  - A faulting request never touches the RAM.
- Loads, little-endian:
  - Byte lane is addr[1:0]; halfword lane is addr[1].
  - lb/lh sign-extend to 32 bits; lbu/lhu zero-extend.
- Stores:
  - A byte-enable mask is derived from size and addr[1:0].
  - Only enabled bytes change.
  - sb writes wdata[7:0] into the lane; sh writes wdata[15:0].
- Reset:
  - Clears FSM to IDLE, counter to 0, `rsp_valid` to 0, `rsp_rdata` to 0, `rsp_err` to 0. `req_ready` reads 1.
  - RAM contents are not cleared.
  - Reset during BUSY aborts the request: a pending store is not committed and no response is issued.

## Timing
- Accept in cycle T (IDLE with `req_valid`).
- Normal request: `rsp_valid` in cycle T+WAIT_CYCLES+1. The default gives T+3.
- Faulting request: `rsp_valid` in cycle T+1, regardless of WAIT_CYCLES.
- `req_ready` returns high in the cycle after RESP. Peak throughput is one request per WAIT_CYCLES+2 cycles.
- A store's data is visible to any load accepted after its RESP cycle.

## Configuration
- `DMEM_FAULT_EN` defined:
  - Fault detection as described above; `rsp_err` driven.
- `DMEM_FAULT_EN` undefined:
  - `rsp_err` is tied to 0.
  - Misaligned addresses are force-aligned by clearing addr[0] for halfwords and addr[1:0] for words.
  - The word index wraps modulo DEPTH_WORDS.
  - Illegal `req_size` is treated as lw.
  - All requests take the full WAIT_CYCLES+1 latency.

## Structure
- Package `dmem_pkg` holds:
  - funct3 size constants (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU);
  - the FSM state typedef (IDLE/BUSY/RESP).
- Sub-module `dmem_lane_align` is combinational and takes size and addr[1:0]. It produces:
  - the store byte-enable mask and lane-shifted write data;
  - the load extract/extend of the RAM word;
  - the misalignment flag.
- The top level holds the FSM, the wait counter, the request latch and the RAM array.

## Test plan
- Reset sequence: `reset`=0 for 2 cycles, then 1 → `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0. The first accept produces a response exactly 3 cycles later.
- Store then load: sw 0x10 with data 0xDEADBEEF, then lw 0x10 → `rsp_rdata`=0xDEADBEEF and `rsp_err`=0. `req_valid` held high during BUSY is not accepted twice.
- Sub-word loads after the store above:
  - lb 0x13 → 0xFFFFFFDE
  - lbu 0x13 → 0x000000DE
  - lh 0x12 → 0xFFFFDEAD
  - lhu 0x10 → 0x0000BEEF
- Partial stores:
  - sb 0x11 with data 0x123456AA, then lw 0x10 → 0xDEADAAEF.
  - sh 0x12 with data 0x00007777, then lw 0x10 → 0x7777AAEF.
- Faults with `DMEM_FAULT_EN` defined:
  - lw 0x12 → `rsp_valid`+`rsp_err` at T+1 and `rsp_rdata`=0.
  - sw 0x400 with data 0xFFFFFFFF → error; a subsequent lw 0x0 is unchanged.
- Reset mid-operation: sw 0x20 with data 0xCAFEF00D accepted, then `reset`=0 in the first BUSY cycle → no `rsp_valid`; after release, lw 0x20 returns the prior contents.
